// File: rtl/cblock_cfg_pkg.sv
// Shared constants and FSM state type for the connection-block config loader.
package cblock_cfg_pkg;

    localparam int CFG_W        = 18;
    localparam int DEF_WR_PULSE = 2;
    localparam int STRB_W       = 4;   // wide enough for WR_PULSE-1 with WR_PULSE up to 15

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        SETUP,
        STROBE,
        HOLD,
        DONE
    } state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cblock_cfg_loader_deser.sv
// Serial-to-parallel deserializer for one 18-bit config word, MSB first.
// Define CBLOCK_CFG_PARITY_EN to expect a trailing even-parity bit per word.
module cfg_deser
    import cblock_cfg_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             accept,
    input  logic             bit_data,
    output logic             word_valid,
    output logic [CFG_W-1:0] word,
    output logic             parity_err
);

`ifdef CBLOCK_CFG_PARITY_EN
    localparam int NBITS = CFG_W + 1;
`else
    localparam int NBITS = CFG_W;
`endif
    // The register holds every bit but the last; the final bit is taken straight
    // from the input so the word is available in the cycle it completes.
    localparam int SHIFT_W = NBITS - 1;
    localparam int CNT_W   = $clog2(NBITS);

    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_bit;

    assign last_bit   = (cnt_q == CNT_W'(NBITS - 1));
    assign word_valid = accept && last_bit;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (clr) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (accept) begin
            shift_d = {shift_q[SHIFT_W-2:0], bit_data};
            cnt_d   = last_bit ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef CBLOCK_CFG_PARITY_EN
    assign word       = shift_q;
    assign parity_err = word_valid && ((^shift_q) ^ bit_data);
`else
    assign word       = {shift_q, bit_data};
    assign parity_err = 1'b0;
`endif

endmodule

// File: rtl/cblock_cfg_loader.sv
// Loads one serial config word per connection block and strobes its latch enable.
// Define CBLOCK_CFG_PARITY_EN to add per-word parity checking and the err flag.
module cblock_cfg_loader
    import cblock_cfg_pkg::*;
#(
    parameter int NUM_BLOCKS = 4,
    parameter int WR_PULSE   = DEF_WR_PULSE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  bit_valid,
    input  logic                  bit_data,
    output logic                  bit_ready,
    output logic [CFG_W-1:0]      cfg_bits,
    output logic [NUM_BLOCKS-1:0] wr_en,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int                IDX_W     = idx_width(NUM_BLOCKS);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_BLOCKS - 1);
    localparam logic [STRB_W-1:0] LAST_STRB = STRB_W'(WR_PULSE - 1);

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [STRB_W-1:0]     strb_q, strb_d;
    logic [CFG_W-1:0]      cfg_q, cfg_d;
    logic [NUM_BLOCKS-1:0] wr_en_q, wr_en_d;
    logic                  bit_ready_q, bit_ready_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  deser_clr;
    logic                  accept;
    logic                  word_valid;
    logic                  parity_err;
    logic [CFG_W-1:0]      word;

    assign deser_clr = (state_q == IDLE) && start;
    assign accept    = bit_valid && bit_ready_q;

    cfg_deser u_deser (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (deser_clr),
        .accept     (accept),
        .bit_data   (bit_data),
        .word_valid (word_valid),
        .word       (word),
        .parity_err (parity_err)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        strb_d  = strb_q;
        cfg_d   = cfg_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    idx_d   = '0;
                    err_d   = 1'b0;
                end
            end
            SHIFT: begin
                if (word_valid) begin
                    if (parity_err) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = SETUP;
                        cfg_d   = word;
                    end
                end
            end
            SETUP: begin
                state_d = STROBE;
                strb_d  = '0;
            end
            STROBE: begin
                if (strb_q == LAST_STRB) state_d = HOLD;
                else                     strb_d  = strb_q + 1'b1;
            end
            HOLD: begin
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    state_d = SHIFT;
                    idx_d   = idx_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so the registered copies line up with it.
        bit_ready_d = (state_d == SHIFT);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
        wr_en_d     = (state_d == STROBE) ? (NUM_BLOCKS'(1) << idx_d) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            strb_q      <= '0;
            cfg_q       <= '0;
            err_q       <= 1'b0;
            wr_en_q     <= '0;
            bit_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            strb_q      <= strb_d;
            cfg_q       <= cfg_d;
            err_q       <= err_d;
            wr_en_q     <= wr_en_d;
            bit_ready_q <= bit_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bit_ready = bit_ready_q;
    assign cfg_bits  = cfg_q;
    assign wr_en     = wr_en_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_cblock_cfg_loader.sv
// Scoreboard bench for cblock_cfg_loader: expected words are queued as bits are
// sent and popped at each wr_en pulse; protocol invariants are checked every cycle.
`timescale 1ns/1ps
module tb_cblock_cfg_loader;
    import cblock_cfg_pkg::*;

    localparam int NB = 4;
    localparam int WP = 2;
`ifdef CBLOCK_CFG_PARITY_EN
    localparam int BPW = CFG_W + 1;
`else
    localparam int BPW = CFG_W;
`endif
    localparam int PER = BPW + 1 + WP + 1;

    logic          clk = 1'b0;
    logic          rst_n, start, bit_valid, bit_data;
    logic          bit_ready, busy, done, err;
    logic [CFG_W-1:0] cfg_bits;
    logic [NB-1:0] wr_en;

    cblock_cfg_loader #(.NUM_BLOCKS(NB), .WR_PULSE(WP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bit_valid (bit_valid),
        .bit_data  (bit_data),
        .bit_ready (bit_ready),
        .cfg_bits  (cfg_bits),
        .wr_en     (wr_en),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int               blk;
        logic [CFG_W-1:0] word;
    } exp_t;

    exp_t             exp_q[$];
    bit               bits_q[$];
    logic [CFG_W-1:0] words [NB];
    int               n_tests = 0;
    int               n_fail  = 0;
    int               t0, done_cyc, done_cnt, acc_cnt, pulse_len;
    int               stall_at  = -1;
    int               stall_cnt = 0;
    int               pulse_cyc [NB];
    logic [NB-1:0]    prev_wr  = '0;
    logic [CFG_W-1:0] prev_cfg = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic monitor();
        exp_t          e;
        logic [NB-1:0] sel;
        if (!rst_n) begin
            prev_wr   = wr_en;
            prev_cfg  = cfg_bits;
            pulse_len = 0;
            return;
        end
        check("onehot", 32'($countones(wr_en) <= 1), 1);
        if (wr_en != 0 || prev_wr != 0) check("cfg_stable", cfg_bits, prev_cfg);
        if (wr_en != 0 && prev_wr == 0) begin
            pulse_len = 1;
            if (exp_q.size() == 0) begin
                check("unexpected_wr", wr_en, 0);
            end else begin
                e = exp_q.pop_front();
                sel = '0;
                sel[e.blk] = 1'b1;
                check("wr_en_sel", wr_en, sel);
                check("cfg_bits", cfg_bits, e.word);
                pulse_cyc[e.blk] = cyc;
            end
        end else if (wr_en != 0) begin
            pulse_len++;
            check("wr_steady", wr_en, prev_wr);
        end else if (prev_wr != 0) begin
            check("pulse_len", pulse_len, WP);
        end
        if (stall_cnt > 0) check("stall_ready", bit_ready, 1);
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        prev_wr  = wr_en;
        prev_cfg = cfg_bits;
    endtask

    task automatic drive_bits();
        if (stall_cnt > 0) begin
            bit_valid = 1'b0;
            stall_cnt--;
        end else if (bits_q.size() > 0) begin
            bit_valid = 1'b1;
            bit_data  = bits_q[0];
            if (bit_ready) begin
                void'(bits_q.pop_front());
                acc_cnt++;
                if (acc_cnt == stall_at) stall_cnt = 5;
            end
        end else begin
            bit_valid = 1'b0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        drive_bits();
    endtask

    task automatic load_seq(input int bad_blk);
        exp_t e;
        for (int b = 0; b < NB; b++) begin
            for (int i = CFG_W - 1; i >= 0; i--) bits_q.push_back(words[b][i]);
`ifdef CBLOCK_CFG_PARITY_EN
            bits_q.push_back((^words[b]) ^ (b == bad_blk));
`endif
            if (bad_blk < 0 || b < bad_blk) begin
                e.blk  = b;
                e.word = words[b];
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic start_seq();
        acc_cnt   = 0;
        done_cnt  = 0;
        stall_cnt = 0;
        for (int b = 0; b < NB; b++) pulse_cyc[b] = -1;
        start = 1'b1;
        t0    = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int dup_at);
        int i;
        i = 0;
        while (done_cnt == 0 && i < 600) begin
            if (i == dup_at) start = 1'b1;
            tick();
            start = 1'b0;
            i++;
        end
        check("done_seen", done_cnt, 1);
        repeat (4) tick();
        check("done_once", done_cnt, 1);
        check("idle_busy", busy, 0);
        check("sb_empty", exp_q.size(), 0);
        bits_q.delete();
        exp_q.delete();
    endtask

    task automatic check_timing(input int extra_blk1);
        for (int b = 0; b < NB; b++)
            check("pulse_time", pulse_cyc[b] - t0, 1 + b * PER + BPW + 1 + ((b >= 1) ? extra_blk1 : 0));
        // Inclusive count from the start cycle through the done cycle.
        check("seq_len", done_cyc - t0 + 1, 1 + NB * PER + 1 + extra_blk1);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        bit_valid = 1'b0;
        bit_data  = 1'b0;
        repeat (3) tick();
        check("rst_cfg", cfg_bits, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_ready", bit_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;
        tick();

        // Nominal four-block load with continuous bits.
        words = '{18'h3FFFF, 18'h00000, 18'h2AAAA, 18'h15555};
        load_seq(-1);
        start_seq();
        check("busy_after_start", busy, 1);
        wait_done(-1);
        check_timing(0);
        check("err_clean", err, 0);

        // Five-cycle stall after bit 7 of word 1.
        words = '{18'h12345, 18'h0F0F3, 18'h3C3C3, 18'h00001};
        stall_at = BPW + 8;
        load_seq(-1);
        start_seq();
        wait_done(-1);
        check_timing(5);
        stall_at = -1;

        // A start pulse while busy must be ignored.
        words = '{18'h1F00F, 18'h20001, 18'h0ABCD, 18'h3FFFE};
        load_seq(-1);
        start_seq();
        wait_done(30);
        check_timing(0);

        // Reset during the second STROBE cycle of block 2, then reload from block 0.
        for (int b = 0; b < NB; b++) words[b] = CFG_W'($urandom);
        load_seq(-1);
        start_seq();
        for (int i = 0; i < 300 && wr_en != 4'b0100; i++) tick();
        check("blk2_strobe", wr_en, 4'b0100);
        tick();
        check("blk2_strobe2", wr_en, 4'b0100);
        rst_n = 1'b0;
        tick();
        check("midrst_wr_en", wr_en, 0);
        check("midrst_busy", busy, 0);
        check("midrst_cfg", cfg_bits, 0);
        check("midrst_ready", bit_ready, 0);
        rst_n = 1'b1;
        bits_q.delete();
        exp_q.delete();
        stall_cnt = 0;
        tick();
        words = '{18'h2468A, 18'h13579, 18'h3F00F, 18'h00FF0};
        load_seq(-1);
        start_seq();
        wait_done(-1);
        check_timing(0);

`ifdef CBLOCK_CFG_PARITY_EN
        // Bad parity on word 1: only block 0 is written, err set and sticky.
        words = '{18'h11111, 18'h22222, 18'h33333, 18'h04444};
        load_seq(1);
        start_seq();
        wait_done(-1);
        check("par_err_set", err, 1);
        check("par_blk0_only", pulse_cyc[0] - t0, BPW + 2);
        words = '{18'h0AAAA, 18'h35555, 18'h00F0F, 18'h3F0F0};
        load_seq(-1);
        start_seq();
        check("par_err_clr", err, 0);
        wait_done(-1);
        check_timing(0);
        check("par_err_clean", err, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/cblock_cfg_loader.md
CBLOCK_CFG_LOADER -- requirements
Module: cblock_cfg_loader

Interface
REQ-001: Parameter NUM_BLOCKS, default 4, SHALL set the number of connection blocks loaded per sequence.
REQ-002: Parameter WR_PULSE, default 2, SHALL set the number of cycles wr_en is held high per block (legal range 1..15).
REQ-003: clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-004: rst_n  input  1  reset; synchronous, active-low.
REQ-005: start  input  1  high for one cycle in IDLE begins a load sequence.
REQ-006: bit_valid  input  1  serial config bit present.
REQ-007: bit_data  input  1  serial config bit value.
REQ-008: bit_ready  output  1  loader accepts bit_data this cycle.
REQ-009: cfg_bits  output  18  shared config word to all blocks' bits inputs.
REQ-010: wr_en  output  NUM_BLOCKS  one-hot latch enable, bit i to block i.
REQ-011: busy  output  1  high in every state except IDLE.
REQ-012: done  output  1  one-cycle pulse at sequence end.
REQ-013: err  output  1  sticky error flag, cleared on accepted start.

Function
REQ-014: FSM states SHALL be IDLE, SHIFT, SETUP, STROBE, HOLD, DONE.
REQ-015: IDLE -> SHIFT on start, with block index = 0, bit count = 0 and err cleared; start outside IDLE SHALL be ignored.
REQ-016: bit_ready SHALL be high only in SHIFT; a bit is accepted when bit_valid && bit_ready.
REQ-017: Accepted bits SHALL shift in MSB-first: shift = {shift[16:0], bit_data}; the first bit lands in cfg_bits[17].
REQ-018: Stalls (bit_valid low) SHALL hold all state; the loader has no timeout.
REQ-019: After the 18th accepted bit, cfg_bits SHALL load from shift on the next edge, and the FSM SHALL enter SETUP.
REQ-020: cfg_bits SHALL change only on entry to SETUP and SHALL be stable throughout SETUP, STROBE and HOLD.
REQ-021: SETUP SHALL last 1 cycle with wr_en = 0.
REQ-022: STROBE SHALL last exactly WR_PULSE cycles with wr_en = 1 << block index.
REQ-023: HOLD SHALL last 1 cycle with wr_en = 0. It then goes to DONE if block index == NUM_BLOCKS-1; otherwise it increments the index and returns to SHIFT.
REQ-024: DONE SHALL last 1 cycle with done = 1, then go to IDLE.
REQ-025: At most one wr_en bit SHALL be high in any cycle; wr_en SHALL be 0 outside STROBE.
REQ-026: Block index width SHALL be $clog2(NUM_BLOCKS), with a minimum of 1; it SHALL never exceed NUM_BLOCKS-1.
REQ-027: Minimum sequence length with bit_valid held high SHALL be 1 + NUM_BLOCKS*(18 + 1 + WR_PULSE + 1) + 1 cycles from start to done.

Reset
REQ-028: When rst_n is low at a clock edge, the FSM SHALL go to IDLE, and counters and the shift register SHALL clear.
REQ-029: Reset values SHALL be: cfg_bits = 0, wr_en = 0, bit_ready = 0, busy = 0, done = 0, err = 0.
REQ-030: Reset mid-STROBE SHALL drop wr_en to 0 on that edge; that block's latch keeps whatever it captured. No partial-sequence resume.

Configuration
REQ-031: Macro CBLOCK_CFG_PARITY_EN, when defined, SHALL add one parity bit after each 18-bit word, making 19 accepted bits per block.
REQ-032: With CBLOCK_CFG_PARITY_EN, the XOR of all 19 bits SHALL be 0. On a mismatch the FSM SHALL skip SETUP, STROBE and HOLD for that block, set err = 1, and go to DONE, with no wr_en asserted for that or any later block.
REQ-033: Without CBLOCK_CFG_PARITY_EN, exactly 18 bits SHALL be accepted per block and err SHALL be tied to 0.

Structure
REQ-034: Package cblock_cfg_pkg SHALL hold CFG_W = 18, the FSM state enum type, and the default WR_PULSE.
REQ-035: Sub-module cfg_deser SHALL contain the shift register, bit counter and optional parity check. It SHALL present word_valid as a one-cycle pulse and parity_err. The top level contains the FSM, block index and strobe counter.

Verification
REQ-036: Reset, then NUM_BLOCKS=4, WR_PULSE=2, stream 0x3FFFF, 0x00000, 0x2AAAA, 0x15555 with bit_valid high -> wr_en pulses 0001, 0010, 0100, 1000 for 2 cycles each. cfg_bits equals the matching word in each pulse. done occurs 90 cycles after start.
REQ-037: Deassert bit_valid for 5 cycles after bit 7 of word 1 -> no state change during the stall; wr_en[1] timing shifts by exactly 5 cycles.
REQ-038: Pulse start while busy -> ignored; the sequence completes unchanged with exactly one done.
REQ-039: Assert rst_n = 0 during the second STROBE cycle of block 2 -> wr_en = 0 and busy = 0 on that edge. A new start afterwards reloads from block 0.
REQ-040: CBLOCK_CFG_PARITY_EN defined, word 1 sent with bad parity -> wr_en[0] pulses and no later wr_en pulses occur. err = 1 with a done pulse, and err clears on the next start.
REQ-041: Check every cycle -> wr_en is one-hot or zero, and cfg_bits is unchanged while any wr_en bit is high and during the cycle before and after.
